vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 vga_clk  in  1  pixel clock (25 MHz); all logic on its rising edge.
REQ-002 clr  in  1  synchronous, active-high reset.
REQ-003 rdn  in  1  display read request, active low; from the VGA sync block.
REQ-004 row_addr  in  9  display row; col_addr  in  10  display column.
REQ-005 vs  in  1  vertical sync; low during sync pulse.
REQ-006 d_out  out  12  display pixel, bbbb_gggg_rrrr.
REQ-007 w0_req  in  1; w0_addr  in  19 ({row,col}); w0_data  in  12; w0_ack  out  1  (writer 0: background drawer).
REQ-008 w1_req, w1_addr, w1_data, w1_ack: same widths as writer 0 (writer 1: sprite drawer).
REQ-009 ram_addr  out  20; ram_din  out  12; ram_we  out  1; ram_dout  in  12  (single-port sync RAM, 1-cycle read latency).
REQ-010 swap_req  in  1  buffer-swap request pulse; front_buf  out  1; swap_done  out  1.

Function
REQ-011 Each cycle the arbiter SHALL pick one slot in state register slot: IDLE, DISP, WR0, WR1. ram_addr/ram_din/ram_we/acks SHALL be registered from that choice.
REQ-012 rdn==0 SHALL select DISP unconditionally: ram_addr[18:0]={row_addr,col_addr}, ram_we=0, both acks 0.
REQ-013 rdn==1 with one eligible writer SHALL select that writer: ram_addr[18:0]=wN_addr, ram_din=wN_data, ram_we=1, wN_ack=1 in the same registered cycle.
REQ-014 rdn==1 with both eligible SHALL grant round-robin: the writer not granted last. The last-grant pointer updates only on a write grant.
REQ-015 A writer SHALL be ineligible in the cycle after its ack is high, so a held stale req is not written twice. The writer presents its next request or drops req after seeing ack.
REQ-016 Writers SHALL hold req/addr/data stable until ack. Pending requests SHALL wait through DISP cycles without loss.
REQ-017 No request and rdn==1 SHALL select IDLE: ram_we=0, acks 0, ram_addr holds.
REQ-018 Display latency: row_addr/col_addr at cycle N appear on ram_addr at N+1. d_out SHALL be loaded from ram_dout at the end of N+2, only when slot at N+1 was DISP. Otherwise d_out holds.
REQ-019 At most one ack SHALL be high per cycle. ack and ram_we SHALL never be high while slot==DISP.
REQ-020 Address arithmetic SHALL be pure concatenation (no wrap). Out-of-range columns (>=640) SHALL pass through unchanged.

Reset
REQ-021 On clr=1 at a rising edge: slot=IDLE, ram_we=0, ram_addr=0, ram_din=0, acks=0, d_out=0, last-grant favours writer 0 next, front_buf=0, swap pending=0, swap_done=0.
REQ-022 clr asserted mid-write SHALL abort the write with no ack. The writer SHALL re-request after reset.

Configuration
REQ-023 Macro DOUBLE_BUFFER_EN defined: a swap_req pulse sets swap pending. On a vs 1->0 transition with pending set, front_buf SHALL toggle, pending SHALL clear, and swap_done SHALL pulse for 1 cycle. Display uses ram_addr[19]=front_buf; writes use ram_addr[19]=~front_buf. A swap_req coinciding with the edge SHALL be applied at that edge.
REQ-024 Macro not defined: ram_addr[19]=0, swap_req ignored, front_buf=0, swap_done=0. Port list is unchanged.

Verification
REQ-025 Reset, then rdn=0, row=5, col=7 -> ram_addr=0x01407 next cycle, ram_we=0. ram_dout=0xABC -> d_out=0xABC one cycle later.
REQ-026 rdn=1, w0_req held, addr 0x00010, data 0x0F0 -> one ram_we pulse with w0_ack. No second write in the following cycle.
REQ-027 rdn=1, both reqs held continuously -> grants alternate W0,W1,W0,W1 over 8 cycles, never a back-to-back duplicate.
REQ-028 w1_req raised while rdn=0 for 10 cycles -> no ram_we, no ack. Write occurs the first cycle after rdn rises.
REQ-029 DOUBLE_BUFFER_EN: swap_req pulse, then vs falls -> front_buf 0->1 and swap_done pulse. The next write uses ram_addr[19]=0 and the display uses ram_addr[19]=1.
REQ-030 clr pulsed during a WR1 cycle -> all outputs zero next cycle. Held w1_req is granted once after clr drops.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter between VGA display reads and two pixel writers.
// Optional front/back buffer swapping is enabled by defining DOUBLE_BUFFER_EN.
module vram_arbiter #(
  localparam int unsigned ROW_W  = 9,
  localparam int unsigned COL_W  = 10,
  localparam int unsigned WA_W   = ROW_W + COL_W,
  localparam int unsigned RA_W   = WA_W + 1,
  localparam int unsigned PIX_W  = 12
) (
  input  logic              vga_clk,
  input  logic              clr,
  input  logic              rdn,
  input  logic [ROW_W-1:0]  row_addr,
  input  logic [COL_W-1:0]  col_addr,
  input  logic              vs,
  output logic [PIX_W-1:0]  d_out,
  input  logic              w0_req,
  input  logic [WA_W-1:0]   w0_addr,
  input  logic [PIX_W-1:0]  w0_data,
  output logic              w0_ack,
  input  logic              w1_req,
  input  logic [WA_W-1:0]   w1_addr,
  input  logic [PIX_W-1:0]  w1_data,
  output logic              w1_ack,
  output logic [RA_W-1:0]   ram_addr,
  output logic [PIX_W-1:0]  ram_din,
  output logic              ram_we,
  input  logic [PIX_W-1:0]  ram_dout,
  input  logic              swap_req,
  output logic              front_buf,
  output logic              swap_done
);

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_DISP = 2'd1,
    SLOT_WR0  = 2'd2,
    SLOT_WR1  = 2'd3
  } slot_t;

  slot_t             r_slot;
  slot_t             w_slot_nxt;
  logic              r_last_w1;
  logic              r_disp_d;
  logic              r_w0_ack;
  logic              r_w1_ack;
  logic              r_ram_we;
  logic [RA_W-1:0]   r_ram_addr;
  logic [PIX_W-1:0]  r_ram_din;
  logic [PIX_W-1:0]  r_d_out;

  logic              w_w0_elig;
  logic              w_w1_elig;
  logic              w_disp_bank;
  logic              w_wr_bank;
  logic              w_last_nxt;
  logic              w_we_nxt;
  logic              w_ack0_nxt;
  logic              w_ack1_nxt;
  logic [RA_W-1:0]   w_addr_nxt;
  logic [PIX_W-1:0]  w_din_nxt;

  // A writer whose ack is showing this cycle still holds its stale request.
  assign w_w0_elig = w0_req & ~r_w0_ack;
  assign w_w1_elig = w1_req & ~r_w1_ack;

  // Slot choice and the registered RAM/ack values that follow from it.
  always_comb begin
    w_slot_nxt = SLOT_IDLE;
    w_last_nxt = r_last_w1;
    w_we_nxt   = 1'b0;
    w_ack0_nxt = 1'b0;
    w_ack1_nxt = 1'b0;
    w_addr_nxt = r_ram_addr;
    w_din_nxt  = r_ram_din;

    if (!rdn) begin
      w_slot_nxt = SLOT_DISP;
    end else if (w_w0_elig && w_w1_elig) begin
      w_slot_nxt = r_last_w1 ? SLOT_WR0 : SLOT_WR1;
    end else if (w_w0_elig) begin
      w_slot_nxt = SLOT_WR0;
    end else if (w_w1_elig) begin
      w_slot_nxt = SLOT_WR1;
    end

    case (w_slot_nxt)
      SLOT_DISP: begin
        w_addr_nxt = {w_disp_bank, row_addr, col_addr};
      end
      SLOT_WR0: begin
        w_addr_nxt = {w_wr_bank, w0_addr};
        w_din_nxt  = w0_data;
        w_we_nxt   = 1'b1;
        w_ack0_nxt = 1'b1;
        w_last_nxt = 1'b0;
      end
      SLOT_WR1: begin
        w_addr_nxt = {w_wr_bank, w1_addr};
        w_din_nxt  = w1_data;
        w_we_nxt   = 1'b1;
        w_ack1_nxt = 1'b1;
        w_last_nxt = 1'b1;
      end
      default: begin
        w_addr_nxt = r_ram_addr;
      end
    endcase
  end

  // Slot register with its registered RAM port, acks and display pixel.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      r_slot     <= SLOT_IDLE;
      r_last_w1  <= 1'b1;
      r_disp_d   <= 1'b0;
      r_w0_ack   <= 1'b0;
      r_w1_ack   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_d_out    <= '0;
    end else begin
      r_slot     <= w_slot_nxt;
      r_last_w1  <= w_last_nxt;
      r_disp_d   <= (r_slot == SLOT_DISP);
      r_w0_ack   <= w_ack0_nxt;
      r_w1_ack   <= w_ack1_nxt;
      r_ram_we   <= w_we_nxt;
      r_ram_addr <= w_addr_nxt;
      r_ram_din  <= w_din_nxt;
      if (r_disp_d) begin
        r_d_out <= ram_dout;
      end
    end
  end

  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign ram_we   = r_ram_we;
  assign w0_ack   = r_w0_ack;
  assign w1_ack   = r_w1_ack;
  assign d_out    = r_d_out;

`ifdef DOUBLE_BUFFER_EN
  logic r_front_buf;
  logic r_swap_pend;
  logic r_swap_done;
  logic r_vs_d;
  logic w_vs_fall;

  assign w_vs_fall = r_vs_d & ~vs;

  // A swap request coinciding with the vsync falling edge is taken at that edge.
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      r_front_buf <= 1'b0;
      r_swap_pend <= 1'b0;
      r_swap_done <= 1'b0;
      r_vs_d      <= 1'b0;
    end else begin
      r_vs_d      <= vs;
      r_swap_done <= 1'b0;
      if (w_vs_fall && (r_swap_pend || swap_req)) begin
        r_front_buf <= ~r_front_buf;
        r_swap_pend <= 1'b0;
        r_swap_done <= 1'b1;
      end else if (swap_req) begin
        r_swap_pend <= 1'b1;
      end
    end
  end

  assign w_disp_bank = r_front_buf;
  assign w_wr_bank   = ~r_front_buf;
  assign front_buf   = r_front_buf;
  assign swap_done   = r_swap_done;
`else
  logic w_unused_swap;

  assign w_unused_swap = ^{swap_req, vs};
  assign w_disp_bank   = 1'b0;
  assign w_wr_bank     = 1'b0;
  assign front_buf     = 1'b0;
  assign swap_done     = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a rule-level model checked every cycle plus directed
// literal expectations. Honours DOUBLE_BUFFER_EN when defined for the build.
module tb_vram_arbiter;

`ifdef DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam logic [31:0] BANK1 = 32'h80000;
  localparam int M_IDLE = 0;
  localparam int M_DISP = 1;
  localparam int M_WR0  = 2;
  localparam int M_WR1  = 3;

  logic        vga_clk = 1'b0;
  logic        clr, rdn, vs;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [11:0] d_out;
  logic        w0_req, w0_ack, w1_req, w1_ack;
  logic [18:0] w0_addr, w1_addr;
  logic [11:0] w0_data, w1_data;
  logic [19:0] ram_addr;
  logic [11:0] ram_din, ram_dout;
  logic        ram_we, swap_req, front_buf, swap_done;

  int n_checks = 0;
  int n_errors = 0;

  vram_arbiter dut (
    .vga_clk(vga_clk), .clr(clr), .rdn(rdn), .row_addr(row_addr), .col_addr(col_addr),
    .vs(vs), .d_out(d_out),
    .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ack(w0_ack),
    .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ack(w1_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .swap_req(swap_req), .front_buf(front_buf), .swap_done(swap_done)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Rule-level model: slot choice from rdn/eligibility, pixel from RAM two cycles after a DISP.
  bit          m_valid = 1'b0;
  int          m_cur, m_prev, m_pick;
  bit          m_last_w1, m_pend, m_vs_prev, m_el0, m_el1, m_wbank;
  logic [19:0] e_addr;
  logic [11:0] e_din, e_dout;
  logic        e_we, e_ack0, e_ack1, e_front, e_done;

  always @(posedge vga_clk) begin
    if (clr) begin
      m_valid = 1'b1;
      m_cur = M_IDLE; m_prev = M_IDLE; m_last_w1 = 1'b1; m_pend = 1'b0;
      e_addr = '0; e_din = '0; e_dout = '0; e_we = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
      e_front = 1'b0; e_done = 1'b0;
    end else if (m_valid) begin
      if (m_prev == M_DISP) e_dout = ram_dout;
      m_el0 = w0_req && !e_ack0;
      m_el1 = w1_req && !e_ack1;
      if (!rdn)                m_pick = M_DISP;
      else if (m_el0 && m_el1) m_pick = m_last_w1 ? M_WR0 : M_WR1;
      else if (m_el0)          m_pick = M_WR0;
      else if (m_el1)          m_pick = M_WR1;
      else                     m_pick = M_IDLE;
      m_wbank = DB && !e_front;
      e_we = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
      if (m_pick == M_DISP) begin
        e_addr = {DB && e_front, row_addr, col_addr};
      end else if (m_pick == M_WR0) begin
        e_addr = {m_wbank, w0_addr}; e_din = w0_data; e_we = 1'b1; e_ack0 = 1'b1; m_last_w1 = 1'b0;
      end else if (m_pick == M_WR1) begin
        e_addr = {m_wbank, w1_addr}; e_din = w1_data; e_we = 1'b1; e_ack1 = 1'b1; m_last_w1 = 1'b1;
      end
      e_done = 1'b0;
      if (DB) begin
        if (m_vs_prev && !vs && (m_pend || swap_req)) begin
          e_front = !e_front; m_pend = 1'b0; e_done = 1'b1;
        end else if (swap_req) begin
          m_pend = 1'b1;
        end
      end
      m_prev = m_cur;
      m_cur  = m_pick;
    end
    m_vs_prev = vs;
  end

  // Per-cycle compare against the model, half a cycle after the active edge.
  always @(negedge vga_clk) begin
    if (m_valid) begin
      chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("m_ram_din", 32'(ram_din), 32'(e_din));
      chk("m_ram_we", 32'(ram_we), 32'(e_we));
      chk("m_w0_ack", 32'(w0_ack), 32'(e_ack0));
      chk("m_w1_ack", 32'(w1_ack), 32'(e_ack1));
      chk("m_d_out", 32'(d_out), 32'(e_dout));
      chk("m_front_buf", 32'(front_buf), 32'(e_front));
      chk("m_swap_done", 32'(swap_done), 32'(e_done));
      chk("m_one_ack", 32'(w0_ack & w1_ack), 32'd0);
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #2;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; rdn = 1'b1; row_addr = '0; col_addr = '0; vs = 1'b1;
    w0_req = 1'b0; w0_addr = '0; w0_data = '0;
    w1_req = 1'b0; w1_addr = '0; w1_data = '0;
    ram_dout = '0; swap_req = 1'b0;
    tick(); tick();
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_acks", 32'({w1_ack, w0_ack}), 32'd0);
    chk("rst_dout", 32'(d_out), 32'd0);
    chk("rst_front", 32'(front_buf), 32'd0);
    clr = 1'b0;

    // Display read: row 5, col 7.
    rdn = 1'b0; row_addr = 9'd5; col_addr = 10'd7;
    tick();
    chk("disp_addr", 32'(ram_addr), 32'h01407);
    chk("disp_we", 32'(ram_we), 32'd0);
    rdn = 1'b1; ram_dout = 12'hABC;
    tick();
    chk("disp_dout_early", 32'(d_out), 32'd0);
    tick();
    chk("disp_dout", 32'(d_out), 32'hABC);
    ram_dout = 12'h111;
    tick();
    chk("disp_dout_hold", 32'(d_out), 32'hABC);

    // Out-of-range column passes straight through.
    rdn = 1'b0; row_addr = 9'd511; col_addr = 10'd1023;
    tick();
    chk("edge_addr", 32'(ram_addr), 32'h7FFFF);
    rdn = 1'b1; ram_dout = 12'h5A5;
    tick(); tick();
    chk("edge_dout", 32'(d_out), 32'h5A5);

    // Single writer: exactly one write per request.
    do_reset();
    w0_req = 1'b1; w0_addr = 19'h00010; w0_data = 12'h0F0;
    tick();
    chk("w0_we", 32'(ram_we), 32'd1);
    chk("w0_ack", 32'({w1_ack, w0_ack}), 32'd1);
    chk("w0_addr", 32'(ram_addr), DB ? 32'h80010 : 32'h00010);
    chk("w0_din", 32'(ram_din), 32'h0F0);
    tick();
    chk("w0_no_dup", 32'(ram_we), 32'd0);
    w0_req = 1'b0;
    tick();
    chk("w0_idle", 32'(ram_we), 32'd0);

    // Both writers held: strict alternation starting with writer 0.
    do_reset();
    w0_req = 1'b1; w0_addr = 19'h00100; w0_data = 12'h111;
    w1_req = 1'b1; w1_addr = 19'h00200; w1_data = 12'h222;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_grant", 32'({w1_ack, w0_ack}), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_din", 32'(ram_din), (i % 2 == 0) ? 32'h111 : 32'h222);
    end
    w0_req = 1'b0; w1_req = 1'b0;
    tick();
    chk("rr_stop", 32'(ram_we), 32'd0);

    // Writer 1 waits through 10 display cycles.
    rdn = 1'b0; row_addr = 9'd1; col_addr = 10'd2; ram_dout = 12'h246;
    w1_req = 1'b1; w1_addr = 19'h12345; w1_data = 12'h3C3;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wait_we", 32'(ram_we), 32'd0);
      chk("wait_acks", 32'({w1_ack, w0_ack}), 32'd0);
    end
    rdn = 1'b1;
    tick();
    chk("wait_ack1", 32'({w1_ack, w0_ack}), 32'd2);
    chk("wait_addr", 32'(ram_addr), DB ? 32'h92345 : 32'h12345);
    chk("wait_din", 32'(ram_din), 32'h3C3);
    w1_req = 1'b0;
    tick();
    chk("wait_done", 32'(ram_we), 32'd0);

    // Reset during a writer-1 cycle, then one grant afterwards.
    w1_req = 1'b1; w1_addr = 19'h00ABC; w1_data = 12'h555;
    tick();
    chk("clr_pre_we", 32'(ram_we), 32'd1);
    chk("clr_pre_dout", 32'(d_out), 32'h246);
    clr = 1'b1;
    tick();
    chk("clr_addr", 32'(ram_addr), 32'd0);
    chk("clr_din", 32'(ram_din), 32'd0);
    chk("clr_we", 32'(ram_we), 32'd0);
    chk("clr_acks", 32'({w1_ack, w0_ack}), 32'd0);
    chk("clr_dout", 32'(d_out), 32'd0);
    clr = 1'b0;
    tick();
    chk("clr_regrant", 32'({w1_ack, w0_ack}), 32'd2);
    w1_req = 1'b0;
    tick();
    chk("clr_once", 32'(ram_we), 32'd0);

    // Buffer swap on vsync falling edge (ignored when the feature is off).
    do_reset();
    vs = 1'b1;
    tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_wait_front", 32'(front_buf), 32'd0);
    tick();
    vs = 1'b0;
    tick();
    chk("swap_front", 32'(front_buf), 32'(DB));
    chk("swap_done", 32'(swap_done), 32'(DB));
    tick();
    chk("swap_done_pulse", 32'(swap_done), 32'd0);
    rdn = 1'b1; w0_req = 1'b1; w0_addr = 19'h00020; w0_data = 12'h0AA;
    tick();
    chk("swap_wr_addr", 32'(ram_addr), 32'h00020);
    w0_req = 1'b0; rdn = 1'b0; row_addr = 9'd3; col_addr = 10'd4;
    tick();
    chk("swap_disp_addr", 32'(ram_addr), DB ? (BANK1 | 32'h00C04) : 32'h00C04);
    rdn = 1'b1; vs = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
